midi_note_decoder: RTL

- Serial MIDI front end for the synthesizer. Receives a UART MIDI stream (8N1, LSB first) on one input pin.
- Parses Note On and Note Off messages for one channel and drives note-event outputs: `on`/`off` one-cycle pulses plus a held 7-bit `note`.
- Sits between the board MIDI input pin and the synthesizer's on/off/note inputs.

---
 rtl/midi_note_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/midi_note_decoder.sv
// midi_note_decoder: 8N1 UART MIDI receiver with a Note On/Off parser for one channel (or omni).
// Drives one-cycle on/off pulses together with the held note/velocity of the most recent event.
`default_nettype none

module midi_note_decoder #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 31_250,
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       on,
  output logic       off,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       framing_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    shreg, shreg_n;
  logic          byte_valid, byte_valid_n;
  logic          framing_n;
  logic          sync1, sync2, prev;
  logic          fall;

  assign fall = prev & ~sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bitn        <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync1       <= rx;
      sync2       <= sync1;
      prev        <= sync2;
      state       <= state_n;
      cnt         <= cnt_n;
      bitn        <= bitn_n;
      shreg       <= shreg_n;
      byte_valid  <= byte_valid_n;
      framing_err <= framing_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt + CW'(1);
    bitn_n       = bitn;
    shreg_n      = shreg;
    byte_valid_n = 1'b0;
    framing_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt == CW'(HALF - 1)) begin
          cnt_n   = '0;
          bitn_n  = '0;
          state_n = sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_n   = '0;
          shreg_n = {sync2, shreg[7:1]};
          bitn_n  = bitn + 3'd1;
          if (bitn == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_n        = '0;
          state_n      = IDLE;
          byte_valid_n = sync2;
          framing_n    = ~sync2;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic       rs_valid;
  logic [7:0] rs;
  logic       idx;
  logic [6:0] d0;
  logic       ev_on, ev_off;
  logic [6:0] ev_note, ev_vel;
  logic       one_byte, wanted, vel_nz;

  assign one_byte = (rs[7:5] == 3'b110);
  assign wanted   = (rs[7:5] == 3'b100) && ((OMNI != 0) || (rs[3:0] == 4'(CHANNEL)));
  assign vel_nz   = (shreg[6:0] != 7'd0);

  // Parser registers the event, then the output stage presents it one clock later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_valid <= 1'b0;
      rs       <= '0;
      idx      <= 1'b0;
      d0       <= '0;
      ev_on    <= 1'b0;
      ev_off   <= 1'b0;
      ev_note  <= '0;
      ev_vel   <= '0;
      on       <= 1'b0;
      off      <= 1'b0;
      note     <= '0;
      velocity <= '0;
    end else begin
      ev_on  <= 1'b0;
      ev_off <= 1'b0;
      if (byte_valid && (shreg < 8'hF8)) begin
        if (shreg[7:4] == 4'hF) begin
          rs_valid <= 1'b0;
          idx      <= 1'b0;
        end else if (shreg[7]) begin
          rs_valid <= 1'b1;
          rs       <= shreg;
          idx      <= 1'b0;
        end else if (rs_valid) begin
          if (one_byte || idx) begin
            idx <= 1'b0;
            if (wanted) begin
              ev_note <= d0;
              ev_vel  <= shreg[6:0];
              ev_on   <= rs[4] && vel_nz;
              ev_off  <= !(rs[4] && vel_nz);
            end
          end else begin
            d0  <= shreg[6:0];
            idx <= 1'b1;
          end
        end
      end
      on  <= ev_on;
      off <= ev_off;
      if (ev_on || ev_off) begin
        note     <= ev_note;
        velocity <= ev_vel;
      end
    end
  end

endmodule

`default_nettype wire
